// File: rtl/instr_fetch.sv
// instr_fetch: instruction-fetch stage of the 16-bit pipelined core.
// It owns the fetch PC and issues word requests to instruction memory using a
// variable-latency req/rdy handshake. Fetched {pc, instr} pairs go through a
// small prefetch FIFO and then into the registered IF/ID output, which supports
// stall, flush (branch/jump redirect) and a sticky halt.
//
// Ports:
//   i_clk, i_rst            clock; synchronous active-high reset
//   i_stall                 hold the IF/ID register, no pop
//   i_flush, i_tgtPc        redirect: clear FIFO, fetch PC <= i_tgtPc
//   i_hlt                   set sticky o_halted
//   o_imemAddr, o_imemReq   memory word address (fetch PC) and request
//   i_imemRdy, i_imemData   memory accept; data valid in the same cycle
//   o_instr, o_pc, o_valid  IF/ID instruction, its PC, real-instruction flag
//   o_halted                sticky halt indication
//
// Build option: define FETCH_BYPASS_EN to load a fetched word straight into the
// IF/ID register when the FIFO is empty (1 instruction/cycle, 1 edge latency).
module instr_fetch #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [15:0] NOP_INSTR  = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [15:0] i_tgtPc,
  input  logic        i_hlt,
  output logic [15:0] o_imemAddr,
  output logic        o_imemReq,
  input  logic        i_imemRdy,
  input  logic [15:0] i_imemData,
  output logic [15:0] o_instr,
  output logic [15:0] o_pc,
  output logic        o_valid,
  output logic        o_halted
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 2) ? 2 : 1;
  localparam int unsigned CntW = 3;
  localparam logic [CntW-1:0] DepthC  = CntW'(FIFO_DEPTH);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(FIFO_DEPTH - 1);

  logic [15:0]     fpc_q;
  logic [15:0]     fifo_pc_q    [FIFO_DEPTH];
  logic [15:0]     fifo_instr_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            halted_q;
  logic [15:0]     instr_q, pc_q;
  logic            valid_q;

  logic fifo_empty, halt_now, hs, bypass, push, pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    fifo_empty = (count_q == '0);
    // A halt seen at this edge already forces the NOP path.
    halt_now   = halted_q | i_hlt;
    o_imemReq  = !i_rst & !halted_q & !i_flush & (count_q < DepthC);
    hs         = o_imemReq & i_imemRdy;
`ifdef FETCH_BYPASS_EN
    // hs already excludes flush.
    bypass     = hs & fifo_empty & !i_stall & !halt_now;
`else
    bypass     = 1'b0;
`endif
    push       = hs & !bypass;
    pop        = !i_flush & !i_stall & !halt_now & !fifo_empty;
  end

  assign o_imemAddr = fpc_q;
  assign o_instr    = instr_q;
  assign o_pc       = pc_q;
  assign o_valid    = valid_q;
  assign o_halted   = halted_q;

  // Storage needs no reset; count and pointers define what is live.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]    <= fpc_q;
      fifo_instr_q[wr_ptr_q] <= i_imemData;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fpc_q    <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
      instr_q  <= NOP_INSTR;
      pc_q     <= 16'h0000;
      valid_q  <= 1'b0;
    end else begin
      if (i_hlt) halted_q <= 1'b1;

      if (i_flush) begin
        fpc_q    <= i_tgtPc;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (hs)   fpc_q    <= fpc_q + 16'd1;
        if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
        case ({push, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end

      // Flush wins over stall; halt takes the NOP path on non-stalled edges.
      if (i_flush || (!i_stall && halt_now)) begin
        instr_q <= NOP_INSTR;
        valid_q <= 1'b0;
      end else if (!i_stall) begin
        if (bypass) begin
          pc_q    <= fpc_q;
          instr_q <= i_imemData;
          valid_q <= 1'b1;
        end else if (!fifo_empty) begin
          pc_q    <= fifo_pc_q[rd_ptr_q];
          instr_q <= fifo_instr_q[rd_ptr_q];
          valid_q <= 1'b1;
        end else begin
          instr_q <= NOP_INSTR;
          valid_q <= 1'b0;
        end
      end
    end
  end

endmodule
